reg_file_sb: RTL

Parametrised register file with a per-register pending-load scoreboard, a dedicated memory-return write port and optional write-to-read bypass. Sits in the CPU datapath in place of the fixed 8×8 register file: port A takes ALU writeback, port B takes load data returning from the data cache. Read ports report whether their operand is valid, so the control unit can stall on read-after-load hazards instead of relying on BUSYWAIT alone.

---
 rtl/reg_file_sb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Register file with a pending-load scoreboard, an ALU write port (A), a load-return
// write port (B) and optional same-cycle forwarding onto the two read ports.
module reg_file_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           BUSYWAIT,
  input  logic [DATA_WIDTH-1:0]          IN,
  input  logic [ADDR_WIDTH-1:0]          INADDRESS,
  input  logic                           WRITE,
  input  logic                           RESERVE,
  input  logic [ADDR_WIDTH-1:0]          RSVADDRESS,
  input  logic [DATA_WIDTH-1:0]          MEMIN,
  input  logic [ADDR_WIDTH-1:0]          MEMADDRESS,
  input  logic                           MEMWRITE,
  input  logic [ADDR_WIDTH-1:0]          OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0]          OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0]          OUT1,
  output logic [DATA_WIDTH-1:0]          OUT2,
  output logic                           OUT1VALID,
  output logic                           OUT2VALID,
  output logic [(1<<ADDR_WIDTH)-1:0]     PENDING,
  output logic                           CONFLICT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]      pending_r;
  logic                  conflict_r;

  logic                  a_try_s;
  logic                  a_eff_s;
  logic                  a_drop_s;
  logic                  b_wr_s;
  logic                  rsv_eff_s;
  logic [DEPTH-1:0]      pending_next_s;

  logic [ADDR_WIDTH-1:0] raddr_s [2];
  logic [DATA_WIDTH-1:0] rdata_s [2];
  logic                  rvalid_s [2];

  assign raddr_s[0] = OUT1ADDRESS;
  assign raddr_s[1] = OUT2ADDRESS;

  // Write-port qualification: writes to a hard-wired zero register are silently ignored
  always_comb begin
    a_try_s   = WRITE && !BUSYWAIT && !(ZERO_REG && (INADDRESS == ADDR_ZERO));
    b_wr_s    = MEMWRITE && !(ZERO_REG && (MEMADDRESS == ADDR_ZERO));
    rsv_eff_s = RESERVE && !BUSYWAIT && !(ZERO_REG && (RSVADDRESS == ADDR_ZERO));
    if (a_try_s && (pending_r[INADDRESS] || (b_wr_s && (MEMADDRESS == INADDRESS)))) begin
      a_drop_s = 1'b1;
      a_eff_s  = 1'b0;
    end else begin
      a_drop_s = 1'b0;
      a_eff_s  = a_try_s;
    end
  end

  // Scoreboard update: a new reservation wins over a load returning to the same register
  always_comb begin
    pending_next_s = pending_r;
    if (b_wr_s) begin
      pending_next_s[MEMADDRESS] = 1'b0;
    end else begin
      pending_next_s = pending_next_s;
    end
    if (rsv_eff_s) begin
      pending_next_s[RSVADDRESS] = 1'b1;
    end else begin
      pending_next_s = pending_next_s;
    end
    if (ZERO_REG) begin
      pending_next_s[0] = 1'b0;
    end else begin
      pending_next_s = pending_next_s;
    end
  end

  // Register array, scoreboard and conflict flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
      pending_r  <= {DEPTH{1'b0}};
      conflict_r <= 1'b0;
    end else begin
      if (a_eff_s) begin
        regs_r[INADDRESS] <= IN;
      end
      if (b_wr_s) begin
        regs_r[MEMADDRESS] <= MEMIN;
      end
      pending_r  <= pending_next_s;
      conflict_r <= a_drop_s;
    end
  end

  // Read ports: zero register, then load-return forward, then ALU forward, then array
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdata_s[i]  = regs_r[raddr_s[i]];
      rvalid_s[i] = !pending_r[raddr_s[i]];
      if (ZERO_REG && (raddr_s[i] == ADDR_ZERO)) begin
        rdata_s[i]  = {DATA_WIDTH{1'b0}};
        rvalid_s[i] = 1'b1;
      end else if (BYPASS && b_wr_s && (MEMADDRESS == raddr_s[i])) begin
        rdata_s[i]  = MEMIN;
        rvalid_s[i] = 1'b1;
      end else if (BYPASS && a_eff_s && (INADDRESS == raddr_s[i])) begin
        rdata_s[i]  = IN;
        rvalid_s[i] = 1'b1;
      end else begin
        rdata_s[i]  = regs_r[raddr_s[i]];
        rvalid_s[i] = !pending_r[raddr_s[i]];
      end
    end
  end

  assign OUT1      = rdata_s[0];
  assign OUT2      = rdata_s[1];
  assign OUT1VALID = rvalid_s[0];
  assign OUT2VALID = rvalid_s[1];
  assign PENDING   = pending_r;
  assign CONFLICT  = conflict_r;

endmodule
